cp0_exc_sequencer: RTL and testbench

//  Exception/interrupt sequencer for the CP0 block of the 5-stage MIPS pipeline.
//  - Prioritises EXE overflow, ID syscall, ID unknown-opcode and external interrupts.
//  - Generates the EPC/CAUSE write strobes, the pipeline flush and the PC redirect.
//  - Runs the ERET return sequence.

---
 rtl/cp0_exc_sequencer_if.sv | 48 ++++
 rtl/cp0_exc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cp0_exc_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_sequencer_if.sv
// Interface bundling the CP0 exception sequencer's pipeline-side inputs and
// its CP0/PC-side strobes.
//   master : pipeline/CP0 side; drives event, status and PC inputs, receives strobes.
//   slave  : the sequencer; receives events, drives flush/redirect/EPC/CAUSE/EXL strobes.
interface cp0_exc_sequencer_if;
  // Events and status
  logic [5:0]  int_req;
  logic [5:0]  im;
  logic        ie;
  logic        exl;
  logic        stall_in;
  logic        id_syscall;
  logic        id_unknown;
  logic        id_eret;
  logic        id_bj;
  logic        exe_overflow;
  logic        mem_bj;
  logic [31:0] id_pc;
  logic [31:0] exe_pc;
  logic [31:0] epc_out;
  // Strobes and status back to CP0 / PC
  logic        exc_flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic        cause_we;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic        exl_set;
  logic        exl_clr;
  logic [5:0]  int_pending;
  logic        busy;

  modport master (
    output int_req, im, ie, exl, stall_in, id_syscall, id_unknown, id_eret, id_bj,
           exe_overflow, mem_bj, id_pc, exe_pc, epc_out,
    input  exc_flush, pc_redirect, redirect_pc, epc_we, epc_wdata, cause_we, exc_code,
           exc_bd, exl_set, exl_clr, int_pending, busy
  );

  modport slave (
    input  int_req, im, ie, exl, stall_in, id_syscall, id_unknown, id_eret, id_bj,
           exe_overflow, mem_bj, id_pc, exe_pc, epc_out,
    output exc_flush, pc_redirect, redirect_pc, epc_we, epc_wdata, cause_we, exc_code,
           exc_bd, exl_set, exl_clr, int_pending, busy
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception/interrupt sequencer for the 5-stage MIPS pipeline.
// Prioritises EXE overflow, ERET, ID syscall, ID unknown opcode and external
// interrupts; sequences CAPT (EPC/CAUSE write) -> FLSH (pipeline flush) ->
// RDIR (redirect to EXC_VECTOR, set EXL), or a single-cycle ERET return.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cp0_exc_sequencer_if.slave (events in, strobes out)
// Configuration macro INT_SYNC_EN: when defined, int_req passes through a
// 2-flop synchroniser; otherwise int_pending follows int_req combinationally.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input logic                   clk,
  input logic                   rst_n,
  cp0_exc_sequencer_if.slave    bus
);

  localparam logic [4:0] CodeOv  = 5'h0c;
  localparam logic [4:0] CodeSys = 5'h08;
  localparam logic [4:0] CodeRi  = 5'h0a;
  localparam logic [4:0] CodeInt = 5'h00;

  typedef enum logic [2:0] {StIdle, StCapt, StFlsh, StRdir, StEret} state_e;

  state_e      state_q, state_d;
  logic [5:0]  int_pending;
  logic        int_hit;
  logic        capture;
  logic [4:0]  code_d, code_q;
  logic [31:0] victim_pc;
  logic        victim_bd;
  logic [31:0] epc_q;
  logic        bd_q;
  logic        epc_en_q;

`ifdef INT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.int_req;
      sync2_q <= sync1_q;
    end
  end

  assign int_pending = sync2_q;
`else
  assign int_pending = bus.int_req;
`endif

  assign int_hit = bus.ie & ~bus.exl & (|(int_pending & bus.im));

  // Next state and capture decode; events are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    code_d    = code_q;
    victim_pc = epc_q;
    victim_bd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.stall_in) begin
          if (bus.exe_overflow) begin
            capture   = 1'b1;
            code_d    = CodeOv;
            victim_bd = bus.mem_bj;
            victim_pc = bus.mem_bj ? (bus.exe_pc - PC_STEP) : bus.exe_pc;
          end else if (bus.id_eret) begin
            // A coincident interrupt is left pending and re-evaluated afterwards.
            state_d = StEret;
          end else if (bus.id_syscall) begin
            capture   = 1'b1;
            code_d    = CodeSys;
            victim_pc = bus.id_pc;
          end else if (bus.id_unknown) begin
            capture   = 1'b1;
            code_d    = CodeRi;
            victim_pc = bus.id_pc;
          end else if (int_hit) begin
            capture   = 1'b1;
            code_d    = CodeInt;
            victim_bd = bus.id_bj;
            victim_pc = bus.id_bj ? (bus.id_pc - PC_STEP) : bus.id_pc;
          end
          if (capture) state_d = StCapt;
        end
      end
      StCapt:  state_d = StFlsh;
      StFlsh:  state_d = StRdir;
      StRdir:  state_d = StIdle;
      StEret:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      code_q   <= '0;
      epc_q    <= '0;
      bd_q     <= 1'b0;
      epc_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        code_q   <= code_d;
        epc_q    <= victim_pc;
        // Nested exception (EXL already set): keep EPC and the old CAUSE.BD.
        bd_q     <= victim_bd & ~bus.exl;
        epc_en_q <= ~bus.exl;
      end
    end
  end

  logic        flush, redirect, epc_we, cause_we, exc_bd, exl_set, exl_clr;
  logic [31:0] redirect_pc, epc_wdata;
  logic [4:0]  exc_code;

  always_comb begin
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    epc_we      = 1'b0;
    cause_we    = 1'b0;
    exc_code    = '0;
    exc_bd      = 1'b0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    unique case (state_q)
      StCapt: begin
        cause_we = 1'b1;
        epc_we   = epc_en_q;
        exc_code = code_q;
        exc_bd   = bd_q;
      end
      StFlsh: flush = 1'b1;
      StRdir: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
        exl_set     = 1'b1;
      end
      StEret: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = bus.epc_out;
        exl_clr     = 1'b1;
      end
      default: ;
    endcase
    epc_wdata = epc_we ? epc_q : 32'd0;
  end

  assign bus.exc_flush   = flush;
  assign bus.pc_redirect = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.epc_we      = epc_we;
  assign bus.epc_wdata   = epc_wdata;
  assign bus.cause_we    = cause_we;
  assign bus.exc_code    = exc_code;
  assign bus.exc_bd      = exc_bd;
  assign bus.exl_set     = exl_set;
  assign bus.exl_clr     = exl_clr;
  assign bus.int_pending = int_pending;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Self-checking bench for cp0_exc_sequencer: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized stimulus against a
// schedule-based reference model (an accepted event expands into a queue of
// per-cycle expected outputs).
module tb_cp0_exc_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  cp0_exc_sequencer_if bus ();

  cp0_exc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic        cause_we;
    logic [4:0]  code;
    logic        bd;
    logic        set;
    logic        clr;
    logic        use_epc_out;
  } exp_t;

  // kind: 0 = exception/interrupt sequence, 1 = eret, 2 = nothing accepted
  typedef struct {
    string       name;
    logic        ovf, sys, unk, eret, id_bj, mem_bj, exl, ie;
    logic [5:0]  irq, im;
    logic [31:0] id_pc, exe_pc, epc_out;
    int          kind;
    logic [4:0]  code;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic        bd;
  } vec_t;

  function automatic exp_t zero_exp();
    exp_t e;
    e.flush = 0; e.redirect = 0; e.rpc = 0; e.epc_we = 0; e.epc_wdata = 0;
    e.cause_we = 0; e.code = 0; e.bd = 0; e.set = 0; e.clr = 0; e.use_epc_out = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e, input logic busy_e);
    chk({tag, ".exc_flush"},   32'(bus.exc_flush),   32'(e.flush));
    chk({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(e.redirect));
    chk({tag, ".redirect_pc"}, bus.redirect_pc,      e.rpc);
    chk({tag, ".epc_we"},      32'(bus.epc_we),      32'(e.epc_we));
    chk({tag, ".epc_wdata"},   bus.epc_wdata,        e.epc_wdata);
    chk({tag, ".cause_we"},    32'(bus.cause_we),    32'(e.cause_we));
    if (e.cause_we) begin
      chk({tag, ".exc_code"}, 32'(bus.exc_code), 32'(e.code));
      chk({tag, ".exc_bd"},   32'(bus.exc_bd),   32'(e.bd));
    end
    chk({tag, ".exl_set"}, 32'(bus.exl_set), 32'(e.set));
    chk({tag, ".exl_clr"}, 32'(bus.exl_clr), 32'(e.clr));
    chk({tag, ".busy"},    32'(bus.busy),    32'(busy_e));
  endtask

  task automatic clear_inputs();
    bus.int_req = 0; bus.im = 0; bus.ie = 0; bus.exl = 0; bus.stall_in = 0;
    bus.id_syscall = 0; bus.id_unknown = 0; bus.id_eret = 0; bus.id_bj = 0;
    bus.exe_overflow = 0; bus.mem_bj = 0; bus.id_pc = 0; bus.exe_pc = 0; bus.epc_out = 0;
  endtask

  task automatic clear_events();
    bus.int_req = 0; bus.id_syscall = 0; bus.id_unknown = 0; bus.id_eret = 0;
    bus.exe_overflow = 0; bus.stall_in = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state for the random phase.
  exp_t       sched[$];
  logic [5:0] h1, h2;

  task automatic push_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic exl);
    exp_t c, f, r;
    c = zero_exp();
    c.cause_we  = 1;
    c.epc_we    = ~exl;
    c.epc_wdata = exl ? 32'd0 : pc;
    c.code      = code;
    c.bd        = exl ? 1'b0 : bd;
    f = zero_exp();
    f.flush = 1;
    r = zero_exp();
    r.redirect = 1; r.rpc = 32'h8; r.set = 1;
    sched.push_back(c);
    sched.push_back(f);
    sched.push_back(r);
  endtask

  vec_t vt[11];

  initial begin
    exp_t e;
    logic was_busy;
    logic [5:0] pend;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();

    // Directed table
    vt[0]  = '{"ovf_bd",     1,0,0,0, 0,1,0,0, 6'h00,6'h00, 32'h0,    32'h40, 32'h0,   0, 5'h0c, 1, 32'h3C,       1};
    vt[1]  = '{"ovf_vs_sys", 1,1,0,0, 0,0,0,0, 6'h00,6'h00, 32'h84,   32'h80, 32'h0,   0, 5'h0c, 1, 32'h80,       0};
    vt[2]  = '{"int_plain",  0,0,0,0, 0,0,0,1, 6'h04,6'h04, 32'h20,   32'h0,  32'h0,   0, 5'h00, 1, 32'h20,       0};
    vt[3]  = '{"int_bd_wrap",0,0,0,0, 1,0,0,1, 6'h21,6'h20, 32'h0,    32'h0,  32'h0,   0, 5'h00, 1, 32'hFFFFFFFC, 1};
    vt[4]  = '{"unk_exl",    0,0,1,0, 1,0,1,0, 6'h00,6'h00, 32'h30,   32'h0,  32'h0,   0, 5'h0a, 0, 32'h0,        0};
    vt[5]  = '{"sys_bj",     0,1,0,0, 1,0,0,0, 6'h00,6'h00, 32'h1234, 32'h0,  32'h0,   0, 5'h08, 1, 32'h1234,     0};
    vt[6]  = '{"eret",       0,0,0,1, 0,0,0,0, 6'h00,6'h00, 32'h0,    32'h0,  32'h100, 1, 5'h00, 0, 32'h0,        0};
    vt[7]  = '{"int_masked", 0,0,0,0, 0,0,0,1, 6'h04,6'h02, 32'h20,   32'h0,  32'h0,   2, 5'h00, 0, 32'h0,        0};
    vt[8]  = '{"int_ie0",    0,0,0,0, 0,0,0,0, 6'h04,6'h04, 32'h20,   32'h0,  32'h0,   2, 5'h00, 0, 32'h0,        0};
    vt[9]  = '{"int_exl",    0,0,0,0, 0,0,1,1, 6'h04,6'h04, 32'h20,   32'h0,  32'h0,   2, 5'h00, 0, 32'h0,        0};
    vt[10] = '{"ovf_exl",    1,0,0,0, 0,1,1,0, 6'h00,6'h00, 32'h0,    32'h40, 32'h0,   0, 5'h0c, 0, 32'h0,        0};

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_all("reset_low", zero_exp(), 0);
    chk("reset_low.int_pending", 32'(bus.int_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_all("reset_rel", zero_exp(), 0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.exe_overflow = vt[i].ovf; bus.id_syscall = vt[i].sys; bus.id_unknown = vt[i].unk;
      bus.id_eret = vt[i].eret; bus.id_bj = vt[i].id_bj; bus.mem_bj = vt[i].mem_bj;
      bus.exl = vt[i].exl; bus.ie = vt[i].ie; bus.int_req = vt[i].irq; bus.im = vt[i].im;
      bus.id_pc = vt[i].id_pc; bus.exe_pc = vt[i].exe_pc; bus.epc_out = vt[i].epc_out;
      bus.stall_in = 1'b1;
      // Stalled cycles: nothing may be accepted.
      repeat (3) begin
        #1 chk({vt[i].name, ".stall_busy"}, 32'(bus.busy), 0);
        @(negedge clk);
      end
      bus.stall_in = 1'b0;
      #1 chk({vt[i].name, ".accept_busy"}, 32'(bus.busy), 0);
      chk({vt[i].name, ".accept_int_pending"}, 32'(bus.int_pending), 32'(vt[i].irq));
      @(negedge clk);
      clear_events();
      #1;
      if (vt[i].kind == 0) begin
        e = zero_exp();
        e.cause_we = 1; e.epc_we = vt[i].epc_we; e.epc_wdata = vt[i].epc_wdata;
        e.code = vt[i].code; e.bd = vt[i].bd;
        check_all({vt[i].name, ".capt"}, e, 1);
        @(negedge clk); #1;
        e = zero_exp(); e.flush = 1;
        check_all({vt[i].name, ".flsh"}, e, 1);
        @(negedge clk); #1;
        e = zero_exp(); e.redirect = 1; e.rpc = 32'h8; e.set = 1;
        check_all({vt[i].name, ".rdir"}, e, 1);
      end else if (vt[i].kind == 1) begin
        e = zero_exp(); e.flush = 1; e.redirect = 1; e.rpc = vt[i].epc_out; e.clr = 1;
        check_all({vt[i].name, ".eret"}, e, 1);
      end else begin
        check_all({vt[i].name, ".none"}, zero_exp(), 0);
      end
      @(negedge clk); #1;
      check_all({vt[i].name, ".idle"}, zero_exp(), 0);
      clear_inputs();
      repeat (3) @(negedge clk);
    end

    // Reset during FLSH drops every strobe immediately.
    @(negedge clk);
    bus.exe_overflow = 1; bus.exe_pc = 32'h200;
    @(negedge clk);
    clear_events();
    @(negedge clk);
    #1 chk("rst_flsh.pre_flush", 32'(bus.exc_flush), 1);
    rst_n = 1'b0;
    #1 check_all("rst_flsh", zero_exp(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_all("rst_flsh.after", zero_exp(), 0);

    // Interrupt coinciding with eret is taken only after the FSM returns to IDLE.
    clear_inputs();
    bus.int_req = 6'h01; bus.im = 6'h01; bus.ie = 1; bus.id_pc = 32'h500; bus.stall_in = 1;
    bus.epc_out = 32'h300;
    repeat (3) @(negedge clk);
    bus.stall_in = 0; bus.id_eret = 1;
    @(negedge clk);
    bus.id_eret = 0;
    #1;
    e = zero_exp(); e.flush = 1; e.redirect = 1; e.rpc = 32'h300; e.clr = 1;
    check_all("eret_int.eret", e, 1);
    @(negedge clk);
    #1 check_all("eret_int.idle", zero_exp(), 0);
    @(negedge clk);
    bus.int_req = 0;
    #1;
    e = zero_exp(); e.cause_we = 1; e.epc_we = 1; e.epc_wdata = 32'h500; e.code = 5'h00;
    check_all("eret_int.capt", e, 1);
    clear_inputs();
    repeat (4) @(negedge clk);

    // int_pending timing relative to int_req.
    bus.stall_in = 1;
    bus.int_req = 6'h2A;
`ifdef INT_SYNC_EN
    #1 chk("sync.lag0", 32'(bus.int_pending), 0);
    @(negedge clk);
    #1 chk("sync.lag1", 32'(bus.int_pending), 0);
    @(negedge clk);
    #1 chk("sync.lag2", 32'(bus.int_pending), 32'h2A);
`else
    #1 chk("sync.comb", 32'(bus.int_pending), 32'h2A);
`endif
    clear_inputs();

    // Randomized phase against the schedule model.
    do_reset();
    sched.delete();
    h1 = 0;
    h2 = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.stall_in     = ($urandom_range(0, 3) == 0);
      bus.exe_overflow = ($urandom_range(0, 15) == 0);
      bus.id_eret      = ($urandom_range(0, 15) == 0);
      bus.id_syscall   = !bus.id_eret && ($urandom_range(0, 15) == 0);
      bus.id_unknown   = !bus.id_eret && ($urandom_range(0, 15) == 0);
      bus.int_req      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      bus.im           = 6'($urandom);
      bus.ie           = 1'($urandom);
      bus.exl          = ($urandom_range(0, 3) == 0);
      bus.id_bj        = 1'($urandom);
      bus.mem_bj       = 1'($urandom);
      bus.id_pc        = $urandom & 32'hFFFF_FFFC;
      bus.exe_pc       = $urandom & 32'hFFFF_FFFC;
      bus.epc_out      = $urandom & 32'hFFFF_FFFC;
      #1;
`ifdef INT_SYNC_EN
      pend = h2;
`else
      pend = bus.int_req;
`endif
      was_busy = (sched.size() != 0);
      if (was_busy) begin
        e = sched.pop_front();
        if (e.use_epc_out) e.rpc = bus.epc_out;
      end else begin
        e = zero_exp();
      end
      check_all("rand", e, was_busy);
      chk("rand.int_pending", 32'(bus.int_pending), 32'(pend));
      if (!was_busy && !bus.stall_in) begin
        if (bus.exe_overflow) begin
          push_exc(5'h0c, bus.mem_bj ? bus.exe_pc - 32'd4 : bus.exe_pc, bus.mem_bj, bus.exl);
        end else if (bus.id_eret) begin
          e = zero_exp();
          e.flush = 1; e.redirect = 1; e.clr = 1; e.use_epc_out = 1;
          sched.push_back(e);
        end else if (bus.id_syscall) begin
          push_exc(5'h08, bus.id_pc, 1'b0, bus.exl);
        end else if (bus.id_unknown) begin
          push_exc(5'h0a, bus.id_pc, 1'b0, bus.exl);
        end else if (bus.ie && !bus.exl && ((pend & bus.im) != 0)) begin
          push_exc(5'h00, bus.id_bj ? bus.id_pc - 32'd4 : bus.id_pc, bus.id_bj, bus.exl);
        end
      end
      h2 = h1;
      h1 = bus.int_req;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
